// File: rtl/opc5ls_io_pkg.sv
// Shared constants for the OPC5LS I/O responder: register map, bit positions,
// UART state encoding and reset values.
package opc5ls_io_pkg;

  localparam logic [3:0] OffTxdata = 4'd0;
  localparam logic [3:0] OffStatus = 4'd1;
  localparam logic [3:0] OffTcnt   = 4'd2;
  localparam logic [3:0] OffTcmp   = 4'd3;
  localparam logic [3:0] OffTctrl  = 4'd4;
  localparam logic [3:0] OffGpio   = 4'd5;

  localparam int unsigned StatFullBit  = 0;
  localparam int unsigned StatEmptyBit = 1;
  localparam int unsigned StatBusyBit  = 2;
  localparam int unsigned StatCntLsb   = 3;
  localparam int unsigned StatCnt4Bit  = 5;
  localparam int unsigned StatOvfBit   = 6;

  localparam int unsigned TctrlEnBit    = 0;
  localparam int unsigned TctrlIrqEnBit = 1;
  localparam int unsigned TctrlFlagBit  = 2;

  localparam logic [15:0] TcntRst = 16'h0000;
  localparam logic [15:0] TcmpRst = 16'hFFFF;
  localparam logic [7:0]  GpioRst = 8'h00;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_state_e;

  function automatic logic [15:0] status_word(input logic full, input logic empty,
                                              input logic busy, input logic [2:0] count,
                                              input logic ovf);
    logic [15:0] s;
    s = '0;
    s[StatFullBit]       = full;
    s[StatEmptyBit]      = empty;
    s[StatBusyBit]       = busy;
    s[StatCntLsb +: 2]   = count[1:0];
    s[StatCnt4Bit]       = (count == 3'd4);
    s[StatOvfBit]        = ovf;
    return s;
  endfunction

endpackage

// File: rtl/opc5ls_uart_tx.sv
// 4-entry TX FIFO feeding an 8N1 LSB-first serializer; frames run back-to-back
// while data is queued.
module opc5ls_uart_tx
  import opc5ls_io_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] data,
  input  logic       clr_ovf,
  output logic       full,
  output logic       empty,
  output logic [2:0] count,
  output logic       busy,
  output logic       ovf,
  output logic       txd
);

  localparam logic [15:0] BaudLast = 16'(BAUD_DIV - 1);

  logic [7:0]  mem_q [4];
  logic [7:0]  mem_d [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic        ovf_q, ovf_d;
  uart_state_e state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        pop, push_ok, bit_end;

  assign full    = (count_q == 3'd4);
  assign empty   = (count_q == 3'd0);
  assign count   = count_q;
  assign busy    = (state_q != StIdle);
  assign ovf     = ovf_q;
  assign bit_end = (baud_q == BaudLast);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    txd     = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        txd = 1'b0;
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StData;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      StData: begin
        txd = shift_q[0];
        if (bit_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = StStop;
          else bit_d = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      StStop: begin
        if (bit_end) begin
          baud_d = '0;
          // Chain straight into the next start bit so queued bytes leave no gap.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    // A pop frees the slot this cycle, so a push into a full FIFO still lands.
    push_ok  = push & (~full | pop);
    mem_d    = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = data;
    wr_ptr_d = wr_ptr_q + 2'(push_ok);
    rd_ptr_d = rd_ptr_q + 2'(pop);
    count_d  = count_q + 3'(push_ok) - 3'(pop);
    ovf_d    = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (push && !push_ok) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
    end
  end

endmodule

// File: rtl/opc5ls_io_responder.sv
// Zero-wait-state I/O page for the OPC5LS CPU: UART TX, compare timer with IRQ,
// and an 8-bit GPIO output register.
module opc5ls_io_responder
  import opc5ls_io_pkg::*;
#(
  parameter logic [15:0] IO_BASE  = 16'hFFF0,
  parameter int unsigned BAUD_DIV = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic        rnw,
  input  logic [15:0] datain,
  output logic [15:0] dataout,
  output logic        sel,
  output logic        txd,
  output logic [7:0]  gpio_out,
  output logic        irq
);

  logic [3:0]  off;
  logic        wr, match;
  logic        tx_full, tx_empty, tx_busy, tx_ovf;
  logic [2:0]  tx_count;
  logic [15:0] tcnt_q, tcnt_d, tcmp_q, tcmp_d;
  logic        en_q, en_d, irq_en_q, irq_en_d, flag_q, flag_d;
  logic [7:0]  gpio_q, gpio_d;

  assign sel      = (address[15:4] == IO_BASE[15:4]);
  assign off      = address[3:0];
  assign wr       = sel & ~rnw & ~reset;
  assign gpio_out = gpio_q;
  assign irq      = flag_q & irq_en_q;

  opc5ls_uart_tx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart_tx (
    .clk     (clk),
    .reset   (reset),
    .push    (wr && (off == OffTxdata)),
    .data    (datain[7:0]),
    .clr_ovf (wr && (off == OffStatus)),
    .full    (tx_full),
    .empty   (tx_empty),
    .count   (tx_count),
    .busy    (tx_busy),
    .ovf     (tx_ovf),
    .txd     (txd)
  );

  always_comb begin
    match    = en_q & (tcnt_q == tcmp_q);
    tcnt_d   = tcnt_q;
    tcmp_d   = tcmp_q;
    en_d     = en_q;
    irq_en_d = irq_en_q;
    flag_d   = flag_q;
    gpio_d   = gpio_q;
    if (en_q) tcnt_d = match ? 16'h0000 : tcnt_q + 16'd1;
    if (wr) begin
      unique case (off)
        OffTcnt: tcnt_d = datain;
        OffTcmp: tcmp_d = datain;
        OffTctrl: begin
          en_d     = datain[TctrlEnBit];
          irq_en_d = datain[TctrlIrqEnBit];
          if (datain[TctrlFlagBit]) flag_d = 1'b0;
        end
        OffGpio: gpio_d = datain[7:0];
        default: ;
      endcase
    end
    // A match outranks a simultaneous clear so no timer event is lost.
    if (match) flag_d = 1'b1;
  end

  always_comb begin
    dataout = '0;
    if (sel) begin
      case (off)
        OffStatus: dataout = status_word(tx_full, tx_empty, tx_busy, tx_count, tx_ovf);
        OffTcnt:   dataout = tcnt_q;
        OffTcmp:   dataout = tcmp_q;
        OffTctrl:  dataout = {13'd0, flag_q, irq_en_q, en_q};
        OffGpio:   dataout = {8'd0, gpio_q};
        default:   dataout = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt_q   <= TcntRst;
      tcmp_q   <= TcmpRst;
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      flag_q   <= 1'b0;
      gpio_q   <= GpioRst;
    end else begin
      tcnt_q   <= tcnt_d;
      tcmp_q   <= tcmp_d;
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      flag_q   <= flag_d;
      gpio_q   <= gpio_d;
    end
  end

endmodule

// File: tb/tb_opc5ls_io_responder.sv
// Directed bench for opc5ls_io_responder with BAUD_DIV=4.
module tb_opc5ls_io_responder;

  localparam int unsigned Baud = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic        rnw;
  logic [15:0] datain;
  logic [15:0] dataout;
  logic        sel;
  logic        txd;
  logic [7:0]  gpio_out;
  logic        irq;

  int nchk = 0;
  int nbad = 0;

  opc5ls_io_responder #(
    .IO_BASE  (16'hFFF0),
    .BAUD_DIV (Baud)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .address  (address),
    .rnw      (rnw),
    .datain   (datain),
    .dataout  (dataout),
    .sel      (sel),
    .txd      (txd),
    .gpio_out (gpio_out),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nchk++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [3:0] off, input logic [15:0] d);
    address = {12'hFFF, off};
    rnw     = 1'b0;
    datain  = d;
    step(1);
    rnw     = 1'b1;
    address = 16'h0100;
    datain  = 16'h0000;
  endtask

  task automatic rd(input string tag, input logic [3:0] off, input logic [15:0] exp);
    address = {12'hFFF, off};
    rnw     = 1'b1;
    #1;
    check(tag, dataout, exp);
    address = 16'h0100;
  endtask

  task automatic get_frame(input string tag, input logic [7:0] exp);
    int n;
    logic [7:0] b;
    n = 0;
    b = '0;
    while (txd !== 1'b0 && n < 200) begin
      step(1);
      n++;
    end
    check({tag, " start"}, {15'd0, txd}, 16'd0);
    step(2);
    for (int i = 0; i < 8; i++) begin
      step(Baud);
      b[i] = txd;
    end
    check(tag, {8'd0, b}, {8'd0, exp});
    step(Baud);
    check({tag, " stop"}, {15'd0, txd}, 16'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  frame;
    logic [15:0] exp_cnt [5];

    reset   = 1'b1;
    rnw     = 1'b1;
    address = 16'h0100;
    datain  = 16'h0000;
    step(2);
    reset = 1'b0;
    check("rst txd", {15'd0, txd}, 16'd1);
    check("rst irq", {15'd0, irq}, 16'd0);
    check("rst gpio", {8'd0, gpio_out}, 16'd0);
    rd("rst status", 4'd1, 16'h0002);
    rd("rst tcnt", 4'd2, 16'h0000);
    rd("rst tcmp", 4'd3, 16'hFFFF);
    rd("rst tctrl", 4'd4, 16'h0000);

    // Decode and GPIO
    step(1);
    address = 16'h0100;
    #1;
    check("fetch sel", {15'd0, sel}, 16'd0);
    check("fetch data", dataout, 16'h0000);
    wr(4'd5, 16'h1234);
    rd("gpio rd", 4'd5, 16'h0034);
    check("gpio out", {8'd0, gpio_out}, 16'h0034);
    for (int o = 6; o < 16; o++) begin
      step(1);
      rd($sformatf("unmapped %0d", o), 4'(o), 16'h0000);
    end
    rd("txdata rd", 4'd0, 16'h0000);
    step(1);

    // Single frame, every clock of every bit
    frame = {1'b1, 8'hA5, 1'b0};
    wr(4'd0, 16'h00A5);
    for (int k = 0; k < 40; k++) begin
      step(1);
      check($sformatf("a5 bit %0d clk %0d", k / 4, k % 4), {15'd0, txd},
            {15'd0, frame[k / 4]});
    end
    step(1);
    rd("a5 status", 4'd1, 16'h0002);
    check("a5 idle txd", {15'd0, txd}, 16'd1);

    // FIFO fill, overflow, push-during-pop while full, ordering
    wr(4'd0, 16'h0011);
    wr(4'd0, 16'h0022);
    wr(4'd0, 16'h0033);
    wr(4'd0, 16'h0044);
    wr(4'd0, 16'h0055);
    wr(4'd0, 16'h0066);
    rd("ovf status", 4'd1, 16'h0065);
    wr(4'd1, 16'h0000);
    rd("ovf cleared", 4'd1, 16'h0025);
    step(34);
    wr(4'd0, 16'h003C);
    rd("full push+pop", 4'd1, 16'h0025);
    get_frame("frame 22", 8'h22);
    get_frame("frame 33", 8'h33);
    get_frame("frame 44", 8'h44);
    get_frame("frame 55", 8'h55);
    get_frame("frame 3c", 8'h3C);
    step(4);
    rd("drained status", 4'd1, 16'h0002);

    // Timer count, flag, irq, clear, stop
    exp_cnt = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0};
    wr(4'd3, 16'h0003);
    wr(4'd4, 16'h0003);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step(1);
      rd($sformatf("tcnt seq %0d", i), 4'd2, exp_cnt[i]);
      check($sformatf("irq seq %0d", i), {15'd0, irq}, (i == 4) ? 16'd1 : 16'd0);
    end
    rd("tctrl flag", 4'd4, 16'h0007);
    wr(4'd4, 16'h0007);
    rd("tctrl cleared", 4'd4, 16'h0003);
    check("irq cleared", {15'd0, irq}, 16'd0);
    rd("tcnt after clr", 4'd2, 16'h0001);
    wr(4'd4, 16'h0000);
    rd("tcnt stop", 4'd2, 16'h0002);
    step(3);
    rd("tcnt held", 4'd2, 16'h0002);

    // Clear colliding with a match, and TCNT load colliding with a match
    wr(4'd4, 16'h0003);
    step(1);
    rd("tcnt at cmp", 4'd2, 16'h0003);
    wr(4'd4, 16'h0007);
    rd("clr vs match", 4'd4, 16'h0007);
    check("irq kept", {15'd0, irq}, 16'd1);
    rd("tcnt wrapped", 4'd2, 16'h0000);
    wr(4'd4, 16'h0007);
    wr(4'd2, 16'h0003);
    wr(4'd2, 16'h0100);
    rd("load vs match", 4'd2, 16'h0100);
    rd("flag on load", 4'd4, 16'h0007);

    // Reset mid-frame with bytes queued; bus write during reset is ignored
    wr(4'd0, 16'h00F0);
    wr(4'd0, 16'h0011);
    wr(4'd0, 16'h0022);
    step(16);
    check("pre-rst bit3", {15'd0, txd}, 16'd0);
    check("pre-rst irq", {15'd0, irq}, 16'd1);
    reset   = 1'b1;
    address = 16'hFFF5;
    rnw     = 1'b0;
    datain  = 16'h00AB;
    step(1);
    reset   = 1'b0;
    rnw     = 1'b1;
    address = 16'h0100;
    datain  = 16'h0000;
    check("abort txd", {15'd0, txd}, 16'd1);
    check("abort irq", {15'd0, irq}, 16'd0);
    check("abort gpio", {8'd0, gpio_out}, 16'h0000);
    rd("abort status", 4'd1, 16'h0002);
    rd("abort tcnt", 4'd2, 16'h0000);
    rd("abort tcmp", 4'd3, 16'hFFFF);
    rd("abort tctrl", 4'd4, 16'h0000);
    step(5);
    check("abort txd held", {15'd0, txd}, 16'd1);
    rd("abort status held", 4'd1, 16'h0002);

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

endmodule

// File: doc/opc5ls_io_responder.md
OPC5LS_IO_RESPONDER -- requirements
Module: opc5ls_io_responder

Interface
REQ-001 SHALL have parameter IO_BASE, default 16'hFFF0: base of the 16-word I/O page, decoded when address[15:4]==IO_BASE[15:4].
REQ-002 SHALL have parameter BAUD_DIV, default 16: clocks per UART bit, legal range 2..65535.
REQ-003 SHALL have port clk, input, 1: single clock, all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port address, input, 16: CPU bus address.
REQ-006 SHALL have port rnw, input, 1: 1=read, 0=write.
REQ-007 SHALL have port datain, input, 16: write data driven by the CPU.
REQ-008 SHALL have port dataout, output, 16: read data returned to the CPU.
REQ-009 SHALL have port sel, output, 1: high when address is in the I/O page.
REQ-010 SHALL have port txd, output, 1: UART serial output.
REQ-011 SHALL have port gpio_out, output, 8: general-purpose outputs.
REQ-012 SHALL have port irq, output, 1: timer interrupt request.

Function
REQ-013 SHALL drive dataout combinationally from address in the same cycle, with zero wait states; dataout SHALL be 0 when sel=0 or the offset is unmapped.
REQ-014 SHALL make reads free of side effects, because the CPU presents fetch addresses continuously.
REQ-015 SHALL perform a write on the rising edge where sel=1 and rnw=0; one write per such cycle.
REQ-016 SHALL map the register offsets (address[3:0]) as follows:
- 0 TXDATA: write pushes datain[7:0] into the TX FIFO; reads 0.
- 1 STATUS: bit0 full, bit1 empty, bit2 tx_busy, bits[4:3] count mod 4, bit5 count==4, bit6 overflow; a write of any value clears overflow.
- 2 TCNT: read/write timer counter.
- 3 TCMP: read/write timer compare.
- 4 TCTRL: bit0 enable, bit1 irq_en, bit2 flag; a write updates bits 0-1, and writing bit2=1 clears the flag.
- 5 GPIO: read/write, bits[7:0] only.
REQ-017 SHALL implement the TX FIFO as 4 entries, first-in first-out; a push while full SHALL be dropped and set overflow.
REQ-018 SHALL, on a simultaneous push and pop while full, accept the push.
REQ-019 SHALL implement the UART transmitter as an FSM IDLE->START->DATA->STOP->IDLE, 8N1, LSB first, each bit lasting BAUD_DIV clocks.
REQ-020 SHALL pop the FIFO on the IDLE->START transition when the FIFO is not empty.
REQ-021 SHALL hold txd=1 in IDLE and STOP and txd=0 in START.
REQ-022 SHALL, from STOP, go directly to START when the FIFO is not empty, so frames are back-to-back with no idle gap.
REQ-023 SHALL drive tx_busy=1 whenever the FSM is not in IDLE.
REQ-024 SHALL run the timer as follows when enable=1: if TCNT==TCMP, TCNT becomes 0 next cycle and flag sets; otherwise TCNT increments by 1, wrapping 16'hFFFF->0.
REQ-025 SHALL hold TCNT while enable=0.
REQ-026 SHALL, when a CPU write to TCNT coincides with a match, load the written value into TCNT and still set flag.
REQ-027 SHALL, when a flag-clear write coincides with a match, leave flag set.
REQ-028 SHALL drive irq = flag & irq_en, registered-state only with no combinational path from the bus.
REQ-029 SHALL let the CPU write TXDATA in the cycle a pop occurs, with no data lost unless the FIFO remains full.

Reset
REQ-030 SHALL, on reset=1 at a clock edge, clear the FIFO to empty, clear overflow, put the UART FSM in IDLE, and drive txd=1.
REQ-031 SHALL, on reset, set TCNT=0, TCMP=16'hFFFF, and enable, irq_en, flag, irq and gpio_out all to 0.
REQ-032 SHALL abort any frame in progress when reset is asserted mid-frame, with txd=1 from the next cycle.
REQ-033 SHALL ignore bus writes in a cycle where reset=1.

Structure
REQ-034 SHALL place register offsets, STATUS/TCTRL bit positions, UART FSM state encodings and reset constants in shared package opc5ls_io_pkg.
REQ-035 SHALL place the FIFO and serializer in sub-module opc5ls_uart_tx, with push/data/full/empty/count/busy/txd ports; the timer, GPIO and decode stay in the top.

Verification
REQ-036 SHALL include directed scenario: write TXDATA=16'h00A5 with BAUD_DIV=4 -> txd sequence 0,1,0,1,0,0,1,0,1, then 1 (start, LSB-first data, stop), each bit 4 clocks; STATUS then reads 16'h0002.
REQ-037 SHALL include directed scenario: 6 writes to TXDATA in consecutive cycles while idle -> first byte popped immediately, 4 buffered, 1 dropped; STATUS bit6=1, full=1; a write to STATUS clears bit6.
REQ-038 SHALL include directed scenario: TCMP=3, TCTRL=3 -> TCNT counts 0,1,2,3,0 and flag/irq rise one cycle after TCNT==3 is first seen; TCTRL write 16'h0007 keeps irq_en and clears flag; write 16'h0000 stops the count.
REQ-039 SHALL include directed scenario: with the address at fetch range 16'h0100, dataout=0 and sel=0; address 16'hFFF5 after writing GPIO=16'h1234 -> dataout=16'h0034 and gpio_out=8'h34; reads of offsets 6..15 return 0.
REQ-040 SHALL include directed scenario: assert reset during DATA bit 3 of a frame with 2 bytes queued -> next cycle txd=1, STATUS=16'h0002, TCNT=0, irq=0.
REQ-041 SHALL include directed scenario: flag-clear write in the same cycle as a match -> flag remains 1.
